// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order writeback FIFO in front of the register file write port.
// Requests from WB are buffered and drained one per cycle whenever rf_grant is high.
// Writes to x0 complete the handshake but are dropped.
// Optional feature macro: REGFILE_WB_BYPASS_EN adds a youngest-match bypass lookup for
// two decode read ports. When it is undefined, the bypass outputs are tied to zero.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [AW-1:0]            wb_addr,
  input  logic [DW-1:0]            wb_data,
  input  logic                     rf_grant,
  output logic [AW-1:0]            rf_addr_rd,
  output logic [DW-1:0]            rf_data_rd,
  output logic                     rf_write_en,
  input  logic [AW-1:0]            byp_addr_rs1,
  output logic                     byp_hit_rs1,
  output logic [DW-1:0]            byp_data_rs1,
  input  logic [AW-1:0]            byp_addr_rs2,
  output logic                     byp_hit_rs2,
  output logic [DW-1:0]            byp_data_rs2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    entry_addr [DEPTH];
  logic [DW-1:0]    entry_data [DEPTH];
  logic [DEPTH-1:0] entry_valid;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             push;
  logic             pop;

  // Readiness depends only on occupancy, so a full queue never passes a request through
  // in the same cycle that it pops.
  assign wb_ready    = (count < CW'(DEPTH));
  assign push        = wb_valid && wb_ready && (wb_addr != '0);
  assign pop         = (count != '0) && rf_grant;
  assign rf_write_en = pop;
  assign rf_addr_rd  = (count != '0) ? entry_addr[rd_ptr] : '0;
  assign rf_data_rd  = (count != '0) ? entry_data[rd_ptr] : '0;

  // Pointers, occupancy and valid bits. A reset drops everything, even mid-drain.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (push) begin
        entry_valid[wr_ptr] <= 1'b1;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        entry_valid[rd_ptr] <= 1'b0;
        rd_ptr              <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload storage. It is only read while the matching valid bit or count
  // covers it, so it needs no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      entry_addr[wr_ptr] <= wb_addr;
      entry_data[wr_ptr] <= wb_data;
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  // Scan entries from oldest to youngest. A later match overwrites an earlier one,
  // so the youngest queued value wins.
  always_comb begin
    byp_hit_rs1  = 1'b0;
    byp_data_rs1 = '0;
    byp_hit_rs2  = 1'b0;
    byp_data_rs2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[rd_ptr + PW'(i)] && (byp_addr_rs1 != '0) &&
          (entry_addr[rd_ptr + PW'(i)] == byp_addr_rs1)) begin
        byp_hit_rs1  = 1'b1;
        byp_data_rs1 = entry_data[rd_ptr + PW'(i)];
      end
      if (entry_valid[rd_ptr + PW'(i)] && (byp_addr_rs2 != '0) &&
          (entry_addr[rd_ptr + PW'(i)] == byp_addr_rs2)) begin
        byp_hit_rs2  = 1'b1;
        byp_data_rs2 = entry_data[rd_ptr + PW'(i)];
      end
    end
  end
`else
  logic unused_byp;

  assign byp_hit_rs1  = 1'b0;
  assign byp_data_rs1 = '0;
  assign byp_hit_rs2  = 1'b0;
  assign byp_data_rs2 = '0;
  assign unused_byp   = ^{byp_addr_rs1, byp_addr_rs2, entry_valid};
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: scoreboard bench for regfile_wb_queue.
// A queue-based reference model tracks occupancy and bypass expectations.
// Accepted writes are pushed to a scoreboard that a separate monitor drains
// whenever the DUT asserts rf_write_en.
module tb_regfile_wb_queue;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } ent_t;

   logic        clock = 1'b1;
   logic        reset_n;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        rf_grant;
   logic [4:0]  rf_addr_rd;
   logic [31:0] rf_data_rd;
   logic        rf_write_en;
   logic [4:0]  byp_addr_rs1;
   logic        byp_hit_rs1;
   logic [31:0] byp_data_rs1;
   logic [4:0]  byp_addr_rs2;
   logic        byp_hit_rs2;
   logic [31:0] byp_data_rs2;
   logic [2:0]  count;

   ent_t model_q[$];
   ent_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   check_en = 1'b0;

   regfile_wb_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
      .clock(clock),
      .reset_n(reset_n),
      .wb_valid(wb_valid),
      .wb_ready(wb_ready),
      .wb_addr(wb_addr),
      .wb_data(wb_data),
      .rf_grant(rf_grant),
      .rf_addr_rd(rf_addr_rd),
      .rf_data_rd(rf_data_rd),
      .rf_write_en(rf_write_en),
      .byp_addr_rs1(byp_addr_rs1),
      .byp_hit_rs1(byp_hit_rs1),
      .byp_data_rs1(byp_data_rs1),
      .byp_addr_rs2(byp_addr_rs2),
      .byp_hit_rs2(byp_hit_rs2),
      .byp_data_rs2(byp_data_rs2),
      .count(count)
   );

   // Free-running clock. It starts high so that the first negedge comes before the first posedge.
   always #5 clock = ~clock;

   // Single comparison point that every check in the bench goes through.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference bypass result: the youngest queued write to a nonzero address, or zero when the bypass is not built.
   function automatic logic [32:0] bypExpect(input logic [4:0] a);
`ifdef REGFILE_WB_BYPASS_EN
      for (int i = model_q.size() - 1; i >= 0; i--)
         if (a != 5'd0 && model_q[i].addr == a) return {1'b1, model_q[i].data};
`endif
      return 33'd0;
   endfunction

   // Monitor: every register-file write must match the oldest outstanding scoreboard entry.
   always @(negedge clock) begin
      if (check_en && rf_write_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write: got addr 0x%0h, expected no write", rf_addr_rd);
         end else begin
            ent_t e;
            e = exp_q.pop_front();
            checkOutput("write_addr", {59'd0, rf_addr_rd}, {59'd0, e.addr});
            checkOutput("write_data", {32'd0, rf_data_rd}, {32'd0, e.data});
         end
      end
   end

   // Drive one cycle of inputs, check the combinational outputs against the model,
   // then advance the model on the clock edge.
   task automatic applyStimulus(input logic rst_n, input logic v, input logic [4:0] a,
                                input logic [31:0] d, input logic g,
                                input logic [4:0] r1, input logic [4:0] r2);
      logic [32:0] b1;
      logic [32:0] b2;
      bit          acc;
      bit          pp;
      reset_n      = rst_n;
      wb_valid     = v;
      wb_addr      = a;
      wb_data      = d;
      rf_grant     = g;
      byp_addr_rs1 = r1;
      byp_addr_rs2 = r2;
      @(negedge clock);
      if (check_en) begin
         b1 = bypExpect(r1);
         b2 = bypExpect(r2);
         checkOutput("wb_ready", {63'd0, wb_ready}, {63'd0, model_q.size() < DEPTH});
         checkOutput("count", {61'd0, count}, 64'(model_q.size()));
         checkOutput("rf_write_en", {63'd0, rf_write_en}, {63'd0, (model_q.size() != 0) && g});
         checkOutput("head_addr", {59'd0, rf_addr_rd}, (model_q.size() != 0) ? {59'd0, model_q[0].addr} : 64'd0);
         checkOutput("head_data", {32'd0, rf_data_rd}, (model_q.size() != 0) ? {32'd0, model_q[0].data} : 64'd0);
         checkOutput("byp_rs1", {31'd0, byp_hit_rs1, byp_data_rs1}, {31'd0, b1});
         checkOutput("byp_rs2", {31'd0, byp_hit_rs2, byp_data_rs2}, {31'd0, b2});
      end
      @(posedge clock);
      if (!rst_n) begin
         model_q.delete();
         exp_q.delete();
      end else begin
         acc = v && (model_q.size() < DEPTH);
         pp  = (model_q.size() != 0) && g;
         if (pp) void'(model_q.pop_front());
         if (acc && a != 5'd0) begin
            model_q.push_back('{addr: a, data: d});
            exp_q.push_back('{addr: a, data: d});
         end
      end
      check_en = 1'b1;
      #1;
   endtask

   // Directed scenarios, then a randomized soak with occasional resets.
   initial begin
      // Reset held for two cycles while a request is offered.
      applyStimulus(1'b0, 1'b1, 5'd3, 32'h1, 1'b0, 5'd0, 5'd0);
      applyStimulus(1'b0, 1'b1, 5'd3, 32'h1, 1'b0, 5'd3, 5'd0);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0);

      // A single write drains on the next cycle.
      applyStimulus(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 5'd0);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0);

      // Fill the queue, stall a fifth request, then drain in order.
      for (int i = 1; i <= 4; i++)
         applyStimulus(1'b1, 1'b1, 5'(i), 32'(i * 17), 1'b0, 5'd2, 5'd4);
      applyStimulus(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 5'd9, 5'd1);
      applyStimulus(1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd1);
      applyStimulus(1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd1);
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd3);

      // Writes to x0 complete the handshake but never reach the register file.
      applyStimulus(1'b1, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 5'd0);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);

      // Two writes to the same register: the bypass must return the younger value.
      applyStimulus(1'b1, 1'b1, 5'd7, 32'hA, 1'b0, 5'd7, 5'd0);
      applyStimulus(1'b1, 1'b1, 5'd7, 32'hB, 1'b0, 5'd7, 5'd0);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7);

      // Reset in the middle of a drain, followed by continuous traffic that wraps the pointers.
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 1'b1, 5'(10 + i), 32'(32'hC0 + i), 1'b0, 5'd11, 5'd12);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 5'd0);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 5'd0);
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b1, 1'b1, 5'(16 + i), 32'(32'hF00 + i), 1'b1, 5'(16 + i), 5'(15 + i));
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);

      // Randomized soak over a small address range, so that x0 and bypass hits are frequent.
      for (int i = 0; i < 400; i++)
         applyStimulus(($urandom_range(0, 99) != 0), 1'($urandom), 5'($urandom_range(0, 7)),
                       $urandom, ($urandom_range(0, 3) != 0),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

      // Final drain: every accepted write must have been seen by the monitor.
      for (int i = 0; i < DEPTH + 2; i++)
         applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
      checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
